led_mode_sequencer: RTL and testbench

//  Sequencer/configurator for a bank of per-LED mode decoders (2-bit mode: 00 off, 01 on, 10 pattern).

---
 rtl/led_mode_sequencer_if.sv | 28 ++
 rtl/led_mode_sequencer.sv | 123 ++++++++++++
 tb/tb_led_mode_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/led_mode_sequencer_if.sv
// Command channel for led_mode_sequencer.
// Host drives valid/chan/mode/dur; sequencer returns ready.
interface led_mode_sequencer_if #(
    parameter int CHAN_W = 2,
    parameter int DUR_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CHAN_W-1:0] cmd_chan;
    logic [1:0]        cmd_mode;
    logic [DUR_W-1:0]  cmd_dur;

    modport master (
        output cmd_valid,
        output cmd_chan,
        output cmd_mode,
        output cmd_dur,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_chan,
        input  cmd_mode,
        input  cmd_dur,
        output cmd_ready
    );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: per-channel 2-bit modes, shared blink, timed revert.
// Ports: clk, rst_n, cmd (slave), clr_all, state_o, pattern1, tick_o, busy_o, err_o.
module led_mode_sequencer #(
    parameter int NUM_LED     = 4,
    parameter int CHAN_W      = 2,
    parameter int PRESCALE    = 1000,
    parameter int BLINK_TICKS = 250,
    parameter int DUR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_mode_sequencer_if.slave    cmd,
    input  logic                   clr_all,
    output logic [2*NUM_LED-1:0]   state_o,
    output logic                   pattern1,
    output logic                   tick_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     PRE_ARM  = PW'(PRESCALE - 2);
    localparam logic [BW-1:0]     BLK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [CHAN_W:0]   NUM_C    = (CHAN_W + 1)'(NUM_LED);
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

    logic [PW-1:0]    pre_cnt;
    logic [BW-1:0]    blk_cnt;
    logic [1:0]       mode_q [NUM_LED];
    logic [DUR_W-1:0] tmr_q  [NUM_LED];

    logic             accept;
    logic             chan_ok;
    logic             bad_mode;
    logic [1:0]       ld_mode;
    logic [DUR_W-1:0] ld_dur;

    assign cmd.cmd_ready = rst_n & ~clr_all;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign chan_ok       = {1'b0, cmd.cmd_chan} < NUM_C;

    // Off commands never arm a timer; reserved mode loads as off.
    always_comb begin
        ld_mode  = 2'b00;
        ld_dur   = '0;
        bad_mode = 1'b0;
        unique case (1'b1)
            (cmd.cmd_mode == 2'b11): bad_mode = 1'b1;
            (cmd.cmd_mode == 2'b00): ld_mode  = 2'b00;
            default: begin
                ld_mode = cmd.cmd_mode;
                ld_dur  = cmd.cmd_dur;
            end
        endcase
    end

    // tick_o is registered: armed one count early so it is high
    // exactly while pre_cnt sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_o  <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            tick_o  <= (pre_cnt == PRE_ARM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt  <= '0;
            pattern1 <= 1'b0;
        end else if (tick_o) begin
            if (blk_cnt == BLK_LAST) begin
                blk_cnt  <= '0;
                pattern1 <= ~pattern1;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    // A command to a channel overrides that channel's tick update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i] <= 2'b00;
                tmr_q[i]  <= '0;
            end
            err_o <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (clr_all) begin
                    mode_q[i] <= 2'b00;
                    tmr_q[i]  <= '0;
                end else if (accept && chan_ok &&
                             cmd.cmd_chan == CHAN_W'(i)) begin
                    mode_q[i] <= ld_mode;
                    tmr_q[i]  <= ld_dur;
                end else if (tick_o && tmr_q[i] != '0) begin
                    if (tmr_q[i] == DUR_ONE) begin
                        mode_q[i] <= 2'b00;
                        tmr_q[i]  <= '0;
                    end else begin
                        tmr_q[i] <= tmr_q[i] - 1'b1;
                    end
                end
            end
            err_o <= accept & (bad_mode | ~chan_ok);
        end
    end

    always_comb begin
        state_o = '0;
        busy_o  = 1'b0;
        for (int i = 0; i < NUM_LED; i++) begin
            state_o[2*i +: 2] = mode_q[i];
            busy_o = busy_o | (tmr_q[i] != '0);
        end
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: per-cycle vector table plus
// reset-timing and async-reset sequences.
module tb_led_mode_sequencer;
    localparam int NL = 3;
    localparam int CW = 2;
    localparam int PS = 4;
    localparam int BT = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_all = 1'b0;
    logic [2*NL-1:0] state_o;
    logic          pattern1;
    logic          tick_o;
    logic          busy_o;
    logic          err_o;

    always #5 clk = ~clk;

    led_mode_sequencer_if #(.CHAN_W(CW), .DUR_W(DW)) bus ();

    led_mode_sequencer #(
        .NUM_LED(NL),
        .CHAN_W(CW),
        .PRESCALE(PS),
        .BLINK_TICKS(BT),
        .DUR_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(bus.slave),
        .clr_all(clr_all),
        .state_o(state_o),
        .pattern1(pattern1),
        .tick_o(tick_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic [1:0] md;
        logic [7:0] dur;
        logic       clr;
        logic [5:0] st;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad = 0;
    int   e = 0;
    int   n;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", nm, e, act, exp);
        end
    endtask

    task automatic add(logic v, logic [1:0] ch, logic [1:0] md,
                       logic [7:0] dur, logic clr, logic [5:0] st,
                       logic b, logic er);
        vec_t t;
        t.v = v; t.ch = ch; t.md = md; t.dur = dur; t.clr = clr;
        t.st = st; t.busy = b; t.err = er;
        tv.push_back(t);
    endtask

    // Idle cycles carry junk payload with valid low.
    task automatic idle(int cnt, logic [5:0] st, logic b);
        repeat (cnt) add(1'b0, 2'd0, 2'b01, 8'd9, 1'b0, st, b, 1'b0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_chan  = '0;
        bus.cmd_mode  = '0;
        bus.cmd_dur   = '0;

        // Ticks act on edges 4,8,12,...; pattern1 toggles on 12,24,36.
        idle(1, 6'b000000, 1'b0);                                   // e1
        add(1, 2'd2, 2'b01, 8'd0, 0, 6'b010000, 0, 0);              // e2
        idle(1, 6'b010000, 1'b0);                                   // e3
        add(1, 2'd1, 2'b10, 8'd3, 0, 6'b011000, 1, 0);              // e4
        idle(11, 6'b011000, 1'b1);                                  // e5-15
        idle(1, 6'b010000, 1'b0);                                   // e16
        add(1, 2'd1, 2'b01, 8'd2, 0, 6'b010100, 1, 0);              // e17
        add(1, 2'd0, 2'b01, 8'd2, 0, 6'b010101, 1, 0);              // e18
        idle(5, 6'b010101, 1'b1);                                   // e19-23
        add(1, 2'd1, 2'b10, 8'd5, 0, 6'b011000, 1, 0);              // e24
        add(1, 2'd2, 2'b11, 8'd6, 0, 6'b001000, 1, 1);              // e25
        add(1, 2'd3, 2'b01, 8'd4, 0, 6'b001000, 1, 1);              // e26
        idle(2, 6'b001000, 1'b1);                                   // e27-28
        add(1, 2'd0, 2'b01, 8'd0, 1, 6'b000000, 0, 0);              // e29
        add(1, 2'd0, 2'b00, 8'd7, 0, 6'b000000, 0, 0);              // e30
        add(1, 2'd0, 2'b01, 8'd1, 0, 6'b000001, 1, 0);              // e31
        idle(1, 6'b000000, 1'b0);                                   // e32
        add(1, 2'd2, 2'b10, 8'd0, 0, 6'b100000, 0, 0);              // e33
        idle(1, 6'b100000, 1'b0);                                   // e34

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_p1", 32'(pattern1), 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            bus.cmd_valid = tv[i].v;
            bus.cmd_chan  = tv[i].ch;
            bus.cmd_mode  = tv[i].md;
            bus.cmd_dur   = tv[i].dur;
            clr_all       = tv[i].clr;
            #1;
            chk("ready", 32'(bus.cmd_ready), 32'(!tv[i].clr));
            @(posedge clk);
            #1;
            e++;
            chk("state", 32'(state_o), 32'(tv[i].st));
            chk("busy", 32'(busy_o), 32'(tv[i].busy));
            chk("err", 32'(err_o), 32'(tv[i].err));
            chk("tick", 32'(tick_o), 32'(e % PS == PS - 1));
            chk("pattern1", 32'(pattern1), 32'((e / (PS * BT)) % 2));
        end

        bus.cmd_valid = 1'b0;
        clr_all = 1'b0;

        n = 0;
        while (!pattern1 && n < 40) begin
            @(posedge clk);
            #1;
            e++;
            n++;
        end
        chk("p1_rise", 32'(pattern1), 32'd1);
        chk("p1_edge", 32'(e), 32'(3 * PS * BT));

        bus.cmd_valid = 1'b1;
        bus.cmd_chan  = 2'd0;
        bus.cmd_mode  = 2'b01;
        bus.cmd_dur   = 8'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_p1", 32'(pattern1), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(state_o), 32'd0);

        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!tick_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_tick", 32'(n), 32'(PS - 1));
        chk("post_state", 32'(state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
